ddfs_burst_ctrl: RTL and testbench

- Control stage directly upstream of the DDFS datapath.
- Decides when the phase accumulator runs and when it is held or cleared: continuous, N-cycle triggered burst, or external-gate mode.
- Counts completed waveform cycles from the DDFS PCO (accumulator carry) output.
- Drives the DDFS BurstEN, Burst_IEG_AP_Sel, start-phase and accumulator-clear inputs.

---
 rtl/ddfs_burst_ctrl.sv | 157 +++++++++++++++
 tb/tb_ddfs_burst_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_burst_ctrl.sv
// Burst/gate control ahead of the DDFS datapath: runs, holds or clears the phase
// accumulator and counts completed waveform cycles from the PCO carry.
module ddfs_burst_ctrl #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned PER_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       Mode,
  input  logic             Trig_Src,
  input  logic             Ext_Trig,
  input  logic             Manual_Trig,
  input  logic             Ext_Gate,
  input  logic             Gate_Pol,
  input  logic [CNT_W-1:0] Burst_Count,
  input  logic [PER_W-1:0] Int_Period,
  input  logic [13:0]      Start_Phase,
  input  logic             PCO,
  output logic             BurstEN,
  output logic             Burst_IEG_AP_Sel,
  output logic             DDFS_Reset,
  output logic [13:0]      Start_Phase_OUT,
  output logic             Burst_Active,
  output logic             Burst_Done,
  output logic             Trig_Out
);

  localparam logic [1:0]       MODE_BURST = 2'b01;
  localparam logic [1:0]       MODE_GATE  = 2'b10;
  localparam logic [PER_W-1:0] PER_MIN    = PER_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_CONT, ST_IDLE, ST_RUN, ST_FINISH} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SYNC_STAGES-1:0] trig_sync;
  logic [SYNC_STAGES-1:0] gate_sync;
  logic               trig_q;
  logic               pco_q;
  logic [1:0]         mode_q;
  logic               src_q;
  logic [1:0]         run_mode;
  logic [PER_W-1:0]   timer;
  logic [CNT_W-1:0]   cnt;
  logic               accept;

  logic               ext_edge;
  logic               gate_act;
  logic               pco_evt;
  logic               timer_en;
  logic               cfg_chg;
  logic               tmr_evt;
  logic               trig_evt;
  logic               mode_burst;
  logic               mode_gate;
  logic               mode_act;
  logic               cnt_last;
  logic [PER_W-1:0]   period_last;

  assign ext_edge    = trig_sync[SYNC_STAGES-1] & ~trig_q;
  assign gate_act    = (gate_sync[SYNC_STAGES-1] == Gate_Pol);
  assign pco_evt     = PCO & ~pco_q;
  assign mode_burst  = (Mode == MODE_BURST);
  assign mode_gate   = (Mode == MODE_GATE);
  assign mode_act    = mode_burst | mode_gate;
  assign period_last = ((Int_Period < PER_MIN) ? PER_MIN : Int_Period) - PER_W'(1);
  assign timer_en    = mode_burst & ~Trig_Src;
  assign cfg_chg     = (Mode != mode_q) | (Trig_Src != src_q);
  // >= keeps the wrap safe when Int_Period shrinks below the running count
  assign tmr_evt     = timer_en & ~cfg_chg & (timer >= period_last);
  assign trig_evt    = (tmr_evt & ~Trig_Src) | (ext_edge & Trig_Src) | Manual_Trig;
  assign cnt_last    = (Burst_Count != '0) && (cnt == Burst_Count - CNT_W'(1));

  // Input synchronisers, edge-detect flops and the internal trigger timer
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      trig_sync <= '0;
      gate_sync <= '0;
      trig_q    <= 1'b0;
      pco_q     <= 1'b0;
      mode_q    <= 2'b00;
      src_q     <= 1'b0;
      timer     <= '0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], Ext_Trig};
      gate_sync <= {gate_sync[SYNC_STAGES-2:0], Ext_Gate};
      trig_q    <= trig_sync[SYNC_STAGES-1];
      pco_q     <= PCO;
      mode_q    <= Mode;
      src_q     <= Trig_Src;
      if (!timer_en || cfg_chg || tmr_evt) timer <= '0;
      else                                  timer <= timer + PER_W'(1);
    end
  end

  // Next-state decode; a trigger taken in IDLE wins over a coincident PCO edge
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_CONT: begin
        if (mode_act) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if ((mode_burst && trig_evt) || (mode_gate && gate_act)) begin
          state_nxt = ST_RUN;
          accept    = 1'b1;
        end else if (!mode_act) begin
          state_nxt = ST_CONT;
        end
      end
      ST_RUN: begin
        if (Mode != run_mode) state_nxt = ST_FINISH;
        else if (pco_evt && ((mode_burst && cnt_last) || (mode_gate && !gate_act)))
          state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        state_nxt = mode_act ? ST_IDLE : ST_CONT;
      end
      default: state_nxt = ST_CONT;
    endcase
  end

  // State, cycle counter and registered outputs decoded from the next state
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= ST_CONT;
      run_mode         <= 2'b00;
      cnt              <= '0;
      BurstEN          <= 1'b0;
      Burst_IEG_AP_Sel <= 1'b0;
      DDFS_Reset       <= 1'b1;
      Start_Phase_OUT  <= '0;
      Burst_Active     <= 1'b0;
      Burst_Done       <= 1'b0;
      Trig_Out         <= 1'b0;
    end else begin
      state            <= state_nxt;
      BurstEN          <= (state_nxt != ST_CONT);
      Burst_IEG_AP_Sel <= mode_gate;
      DDFS_Reset       <= (state_nxt == ST_IDLE) || (state_nxt == ST_FINISH);
      Burst_Active     <= (state_nxt == ST_RUN);
      Burst_Done       <= (state_nxt == ST_FINISH);
      Trig_Out         <= accept;
      if (accept) begin
        Start_Phase_OUT <= Start_Phase;
        run_mode        <= Mode;
        cnt             <= '0;
      end else if ((state == ST_RUN) && pco_evt && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddfs_burst_ctrl.sv
// Scenario bench for ddfs_burst_ctrl: a monitor records triggers, burst lengths and
// trigger times; each task pushes expectations and compares them against the records.
module tb_ddfs_burst_ctrl;
  localparam int unsigned CNT_W       = 24;
  localparam int unsigned PER_W       = 32;
  localparam int unsigned SYNC_STAGES = 2;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic [1:0]       Mode = 2'b00;
  logic             Trig_Src = 1'b0;
  logic             Ext_Trig = 1'b0;
  logic             Manual_Trig = 1'b0;
  logic             Ext_Gate = 1'b0;
  logic             Gate_Pol = 1'b1;
  logic [CNT_W-1:0] Burst_Count = '0;
  logic [PER_W-1:0] Int_Period = 32'd100;
  logic [13:0]      Start_Phase = '0;
  logic             PCO = 1'b0;
  logic             BurstEN, Burst_IEG_AP_Sel, DDFS_Reset, Burst_Active, Burst_Done, Trig_Out;
  logic [13:0]      Start_Phase_OUT;

  int checks = 0;
  int failures = 0;
  int n_trig = 0;
  int n_done = 0;
  int edges = 0;
  int cyc = 0;
  logic pco_prev = 1'b0;
  logic [13:0] obs_phase[$];
  logic [13:0] exp_phase[$];
  int obs_len[$];
  int exp_len[$];
  int obs_time[$];

  ddfs_burst_ctrl #(.CNT_W(CNT_W), .PER_W(PER_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .Clock(Clock), .Reset(Reset), .Mode(Mode), .Trig_Src(Trig_Src), .Ext_Trig(Ext_Trig),
    .Manual_Trig(Manual_Trig), .Ext_Gate(Ext_Gate), .Gate_Pol(Gate_Pol),
    .Burst_Count(Burst_Count), .Int_Period(Int_Period), .Start_Phase(Start_Phase), .PCO(PCO),
    .BurstEN(BurstEN), .Burst_IEG_AP_Sel(Burst_IEG_AP_Sel), .DDFS_Reset(DDFS_Reset),
    .Start_Phase_OUT(Start_Phase_OUT), .Burst_Active(Burst_Active), .Burst_Done(Burst_Done),
    .Trig_Out(Trig_Out)
  );

  always #5 Clock = ~Clock;

  // PCO stand-in: period 8 clocks, 4 high / 4 low
  initial begin
    int pc;
    pc = 0;
    forever begin
      @(posedge Clock);
      #1;
      pc++;
      PCO = ((pc % 8) >= 4);
    end
  end

  // Observation side of the scoreboard
  initial begin
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset) begin
        if (Trig_Out) begin
          obs_phase.push_back(Start_Phase_OUT);
          obs_time.push_back(cyc);
          edges = 0;
          n_trig++;
        end
        if (Burst_Active && PCO && !pco_prev) edges++;
        if (Burst_Done) begin
          obs_len.push_back(edges);
          n_done++;
        end
      end
      pco_prev = PCO;
    end
  end

  initial begin
    #1_000_000;
    checks++;
    failures++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic clear_q();
    obs_phase.delete(); exp_phase.delete();
    obs_len.delete(); exp_len.delete(); obs_time.delete();
  endtask

  task automatic wait_trig(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (Trig_Out) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (Burst_Done) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic pulse_manual();
    tick(1);
    Manual_Trig = 1'b1;
    tick(1);
    Manual_Trig = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Mode  = 2'b00;
    repeat (3) @(negedge Clock);
    checks++; if (DDFS_Reset !== 1'b1) begin failures++; $display("FAIL rst_ddfs_reset got=%b required=1", DDFS_Reset); end
    checks++; if ({BurstEN, Burst_IEG_AP_Sel, Burst_Active, Burst_Done, Trig_Out} !== 5'b0) begin
      failures++; $display("FAIL rst_flags got=%b required=00000", {BurstEN, Burst_IEG_AP_Sel, Burst_Active, Burst_Done, Trig_Out}); end
    checks++; if (Start_Phase_OUT !== 14'h0) begin failures++; $display("FAIL rst_phase got=%h required=0000", Start_Phase_OUT); end
    tick(1);
    Reset = 1'b1;
    @(negedge Clock);
    checks++; if (DDFS_Reset !== 1'b1) begin failures++; $display("FAIL rel_hold got=%b required=1", DDFS_Reset); end
    @(negedge Clock);
    checks++; if (DDFS_Reset !== 1'b0) begin failures++; $display("FAIL rel_ddfs_reset got=%b required=0", DDFS_Reset); end
    checks++; if (BurstEN !== 1'b0) begin failures++; $display("FAIL rel_bursten got=%b required=0", BurstEN); end
  endtask

  task automatic test_ext_burst();
    bit ok;
    logic [13:0] ep, op;
    int el, ol;
    clear_q();
    Trig_Src = 1'b1; Burst_Count = 24'd3; Start_Phase = 14'h0400; Mode = 2'b01;
    tick(4);
    checks++; if ({DDFS_Reset, BurstEN, Burst_Active} !== 3'b110) begin
      failures++; $display("FAIL idle_outputs got=%b required=110", {DDFS_Reset, BurstEN, Burst_Active}); end
    Ext_Trig = 1'b1;
    exp_phase.push_back(14'h0400); exp_len.push_back(3);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checks++; if (Trig_Out !== 1'b0) begin failures++; $display("FAIL trig_early got=%b required=0", Trig_Out); end
    @(negedge Clock);
    checks++; if (Trig_Out !== 1'b1) begin failures++; $display("FAIL trig_latency got=%b required=1", Trig_Out); end
    checks++; if ({DDFS_Reset, Burst_Active} !== 2'b01) begin
      failures++; $display("FAIL run_outputs got=%b required=01", {DDFS_Reset, Burst_Active}); end
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ext_done got=timeout required=pulse"); end
    checks++; if ({DDFS_Reset, Burst_Active} !== 2'b10) begin
      failures++; $display("FAIL finish_outputs got=%b required=10", {DDFS_Reset, Burst_Active}); end
    while (exp_phase.size() > 0) begin
      ep = exp_phase.pop_front(); op = (obs_phase.size() > 0) ? obs_phase.pop_front() : 'x;
      checks++; if (op !== ep) begin failures++; $display("FAIL ext_phase got=%h required=%h", op, ep); end
    end
    while (exp_len.size() > 0) begin
      el = exp_len.pop_front(); ol = (obs_len.size() > 0) ? obs_len.pop_front() : -1;
      checks++; if (ol != el) begin failures++; $display("FAIL ext_len got=%0d required=%0d", ol, el); end
    end
    Ext_Trig = 1'b0;
    tick(4);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t0;
    logic [13:0] ep, op;
    int el, ol;
    clear_q();
    t0 = n_trig;
    Ext_Trig = 1'b1;
    exp_phase.push_back(14'h0400); exp_len.push_back(3);
    wait_trig(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rt_first got=timeout required=trig"); end
    Ext_Trig = 1'b0;
    tick(3);
    Ext_Trig = 1'b1;
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rt_done got=timeout required=pulse"); end
    checks++; if (n_trig - t0 != 1) begin failures++; $display("FAIL rt_ignored got=%0d required=1", n_trig - t0); end
    Start_Phase = 14'h0123;
    tick(3);
    exp_phase.push_back(14'h0123); exp_len.push_back(3);
    pulse_manual();
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL man_done got=timeout required=pulse"); end
    checks++; if (n_trig - t0 != 2) begin failures++; $display("FAIL man_trig got=%0d required=2", n_trig - t0); end
    while (exp_phase.size() > 0) begin
      ep = exp_phase.pop_front(); op = (obs_phase.size() > 0) ? obs_phase.pop_front() : 'x;
      checks++; if (op !== ep) begin failures++; $display("FAIL rt_phase got=%h required=%h", op, ep); end
    end
    while (exp_len.size() > 0) begin
      el = exp_len.pop_front(); ol = (obs_len.size() > 0) ? obs_len.pop_front() : -1;
      checks++; if (ol != el) begin failures++; $display("FAIL rt_len got=%0d required=%0d", ol, el); end
    end
    Ext_Trig = 1'b0;
    tick(4);
  endtask

  task automatic test_int_timer();
    int d;
    int n;
    Mode = 2'b00; tick(2);
    Trig_Src = 1'b0; Int_Period = 32'd100; Burst_Count = 24'd1;
    clear_q();
    Mode = 2'b01;
    for (int i = 0; i < 400 && obs_time.size() < 3; i++) @(negedge Clock);
    #1;
    checks++; if (obs_time.size() < 3) begin failures++; $display("FAIL tmr100_count got=%0d required=3", obs_time.size()); end
    else begin
      for (int i = 1; i < 3; i++) begin
        d = obs_time[i] - obs_time[i-1];
        checks++; if (d != 100) begin failures++; $display("FAIL tmr100_interval got=%0d required=100", d); end
      end
    end
    n = obs_len.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (obs_len[i] != 1) begin failures++; $display("FAIL tmr_len got=%0d required=1", obs_len[i]); end
    end
    Mode = 2'b00; tick(2);
    Int_Period = 32'd1;
    clear_q();
    Mode = 2'b01;
    for (int i = 0; i < 200 && obs_time.size() < 4; i++) @(negedge Clock);
    #1;
    checks++; if (obs_time.size() < 4) begin failures++; $display("FAIL tmr1_count got=%0d required=4", obs_time.size()); end
    else begin
      for (int i = 1; i < 4; i++) begin
        d = obs_time[i] - obs_time[i-1];
        checks++; if ((d % 2) != 0 || d < 4 || d > 20) begin
          failures++; $display("FAIL tmr1_interval got=%0d required=even_4_to_20", d); end
      end
    end
    Mode = 2'b00;
    tick(6);
  endtask

  task automatic test_gated();
    bit ok;
    int e0, d0;
    logic [13:0] ep, op;
    int el, ol;
    Ext_Gate = 1'b0; Gate_Pol = 1'b1; Start_Phase = 14'h0abc;
    clear_q();
    Mode = 2'b10;
    tick(3);
    checks++; if ({Burst_IEG_AP_Sel, DDFS_Reset, Burst_Active} !== 3'b110) begin
      failures++; $display("FAIL gate_idle got=%b required=110", {Burst_IEG_AP_Sel, DDFS_Reset, Burst_Active}); end
    Ext_Gate = 1'b1;
    exp_phase.push_back(14'h0abc);
    wait_trig(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gate_start got=timeout required=trig"); end
    e0 = edges;
    for (int i = 0; i < 20 && edges == e0; i++) @(negedge Clock);
    #1;
    tick(1);
    Ext_Gate = 1'b0;
    exp_len.push_back(edges + 1);
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gate_stop got=timeout required=pulse"); end
    while (exp_len.size() > 0) begin
      el = exp_len.pop_front(); ol = (obs_len.size() > 0) ? obs_len.pop_front() : -1;
      checks++; if (ol != el) begin failures++; $display("FAIL gate_len got=%0d required=%0d", ol, el); end
    end
    tick(3);
    Ext_Gate = 1'b1;
    exp_phase.push_back(14'h0abc);
    wait_trig(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gate_restart got=timeout required=trig"); end
    e0 = edges;
    for (int i = 0; i < 20 && edges == e0; i++) @(negedge Clock);
    #1;
    tick(1);
    Ext_Gate = 1'b0;
    tick(2);
    Ext_Gate = 1'b1;
    d0 = n_done;
    tick(30);
    checks++; if (Burst_Active !== 1'b1 || n_done != d0) begin
      failures++; $display("FAIL gate_reassert got=active%b_done%0d required=active1_done%0d", Burst_Active, n_done, d0); end
    Ext_Gate = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gate_final got=timeout required=pulse"); end
    while (exp_phase.size() > 0) begin
      ep = exp_phase.pop_front(); op = (obs_phase.size() > 0) ? obs_phase.pop_front() : 'x;
      checks++; if (op !== ep) begin failures++; $display("FAIL gate_phase got=%h required=%h", op, ep); end
    end
    Mode = 2'b00;
    tick(4);
  endtask

  task automatic test_abort();
    bit ok;
    int d0;
    Trig_Src = 1'b1; Burst_Count = 24'd0; Mode = 2'b01;
    tick(3);
    d0 = n_done;
    pulse_manual();
    tick(60);
    checks++; if (Burst_Active !== 1'b1 || n_done != d0) begin
      failures++; $display("FAIL inf_running got=active%b_done%0d required=active1_done%0d", Burst_Active, n_done, d0); end
    Mode = 2'b00;
    wait_done(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_done got=timeout required=pulse"); end
    tick(10);
    checks++; if (n_done != d0 + 1) begin failures++; $display("FAIL abort_once got=%0d required=%0d", n_done, d0 + 1); end
    checks++; if ({DDFS_Reset, BurstEN, Burst_Active} !== 3'b000) begin
      failures++; $display("FAIL abort_cont got=%b required=000", {DDFS_Reset, BurstEN, Burst_Active}); end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    Trig_Src = 1'b1; Burst_Count = 24'd0; Start_Phase = 14'h1555; Mode = 2'b01;
    tick(3);
    pulse_manual();
    tick(10);
    checks++; if (Burst_Active !== 1'b1) begin failures++; $display("FAIL mid_active got=%b required=1", Burst_Active); end
    d0 = n_done;
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    checks++; if ({DDFS_Reset, BurstEN, Burst_Active, Burst_Done, Trig_Out, Burst_IEG_AP_Sel} !== 6'b100000) begin
      failures++; $display("FAIL mid_reset got=%b required=100000",
        {DDFS_Reset, BurstEN, Burst_Active, Burst_Done, Trig_Out, Burst_IEG_AP_Sel}); end
    checks++; if (Start_Phase_OUT !== 14'h0) begin failures++; $display("FAIL mid_phase got=%h required=0000", Start_Phase_OUT); end
    tick(5);
    Mode = 2'b00;
    tick(1);
    Reset = 1'b1;
    tick(5);
    checks++; if (n_done != d0) begin failures++; $display("FAIL mid_no_done got=%0d required=%0d", n_done, d0); end
  endtask

  initial begin
    test_reset();
    test_ext_burst();
    test_back_to_back();
    test_int_timer();
    test_gated();
    test_abort();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
